// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage feeding decode.
// Generates the fetch PC, keeps at most one request outstanding to instruction
// memory, buffers returned words in a QDEPTH-entry queue and presents the head
// {pc, instr} pair to decode.  Redirects from decode follow single-delay-slot
// semantics: the word at pc_id+4 is always delivered before the target.
// Optional build macro: IFETCH_PERF_CNT_EN adds redirect/bubble counters.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump_branch,
   input  logic        jump_target,
   input  logic        jump_reg,
   input  logic [31:0] jr_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic        instr_valid_id,
   output logic [31:0] pc_id,
   output logic [31:0] instr_id
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] redirect_count,
   output logic [31:0] bubble_count
`endif
);

   localparam int            PW        = $clog2(QDEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(QDEPTH);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
   localparam logic [PW:0]   CNT_TWO   = (PW+1)'(2);

   // fetch side
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_out_addr;
   logic          r_outstanding;
   logic          r_ftgt_valid;
   logic [31:0]   r_ftgt;
   // response filter
   logic [31:0]   r_exp_pc;
   logic          r_etgt_valid;
   logic [31:0]   r_etgt;
   // queue
   logic [31:0]   r_q_pc    [QDEPTH];
   logic [31:0]   r_q_instr [QDEPTH];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [PW:0]   r_count;

   logic          w_valid;
   logic [31:0]   w_head_pc;
   logic [31:0]   w_head_instr;
   logic          w_pop;
   logic          w_redir;
   logic [31:0]   w_pc4;
   logic [31:0]   w_br_tgt;
   logic [31:0]   w_j_tgt;
   logic [31:0]   w_tgt;
   logic [PW:0]   w_occ;
   logic          w_req;
   logic          w_grant;
   logic          w_arr;
   logic          w_arr_ds;
   logic          w_arr_exp;
   logic          w_case_a;
   logic          w_case_b;
   logic          w_case_c;
   logic          w_ds_now;
   logic          w_push;

   assign w_valid      = (r_count != '0);
   assign w_head_pc    = r_q_pc[r_rptr];
   assign w_head_instr = r_q_instr[r_rptr];
   assign w_pop        = w_valid & ~stall;
   assign w_redir      = w_pop & (jump_branch | jump_target | jump_reg);

   assign w_pc4    = w_head_pc + 32'd4;
   assign w_br_tgt = w_pc4 + {{14{w_head_instr[15]}}, w_head_instr[15:0], 2'b00};
   assign w_j_tgt  = {w_pc4[31:28], w_head_instr[25:0], 2'b00};
   assign w_tgt    = jump_reg ? jr_pc : (jump_target ? w_j_tgt : w_br_tgt);

   // a queue slot is reserved for every outstanding request, so the queue never overflows
   assign w_occ   = r_count + (PW+1)'(r_outstanding);
   assign w_req   = ~rst & (w_occ < CNT_DEPTH);
   assign w_grant = w_req & imem_gnt;

   // only responses to our own outstanding request are considered (drops stale data after reset)
   assign w_arr     = imem_rvalid & r_outstanding;
   assign w_arr_ds  = w_arr & (r_out_addr == w_pc4);
   assign w_arr_exp = w_arr & (r_out_addr == r_exp_pc);

   // A: delay slot already queued; B: delay slot arriving now; C: delay slot not yet received
   assign w_case_a = w_redir & (r_count >= CNT_TWO);
   assign w_case_b = w_redir & (r_count == CNT_ONE) & w_arr_ds;
   assign w_case_c = w_redir & (r_count == CNT_ONE) & ~w_arr_ds;
   // in case C the delay slot may still be requested in this very cycle
   assign w_ds_now = w_case_c & w_grant & (r_fetch_pc == w_pc4);

   assign w_push = w_redir ? w_case_b : w_arr_exp;

   assign imem_req       = w_req;
   assign imem_addr      = r_fetch_pc;
   assign instr_valid_id = w_valid;
   assign pc_id          = w_valid ? w_head_pc : '0;
   assign instr_id       = w_valid ? w_head_instr : '0;

   // fetch PC, outstanding request tracking and deferred redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_out_addr    <= RESET_PC;
         r_outstanding <= 1'b0;
         r_ftgt_valid  <= 1'b0;
         r_ftgt        <= '0;
      end else begin
         if (w_grant) begin
            r_outstanding <= 1'b1;
            r_out_addr    <= r_fetch_pc;
         end else if (imem_rvalid) begin
            r_outstanding <= 1'b0;
         end
         if (w_case_a | w_case_b | w_ds_now) begin
            r_fetch_pc   <= w_tgt;
            r_ftgt_valid <= 1'b0;
         end else if (w_case_c) begin
            // fetch the delay slot first; the target follows once it is granted
            r_fetch_pc   <= w_pc4;
            r_ftgt       <= w_tgt;
            r_ftgt_valid <= 1'b1;
         end else if (w_grant) begin
            r_fetch_pc   <= r_ftgt_valid ? r_ftgt : r_fetch_pc + 32'd4;
            r_ftgt_valid <= 1'b0;
         end
      end
   end

   // expected PC of the next word to enqueue; anything else returned is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp_pc     <= RESET_PC;
         r_etgt_valid <= 1'b0;
         r_etgt       <= '0;
      end else if (w_case_a | w_case_b) begin
         r_exp_pc     <= w_tgt;
         r_etgt_valid <= 1'b0;
      end else if (w_case_c) begin
         r_exp_pc     <= w_pc4;
         r_etgt       <= w_tgt;
         r_etgt_valid <= 1'b1;
      end else if (w_push) begin
         r_exp_pc     <= r_etgt_valid ? r_etgt : r_exp_pc + 32'd4;
         r_etgt_valid <= 1'b0;
      end
   end

   // queue pointers and occupancy; case A keeps only the delay slot entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else if (w_case_a) begin
         r_rptr  <= r_rptr + PTR_ONE;
         r_wptr  <= r_rptr + PTR_ONE + PTR_ONE;
         r_count <= CNT_ONE;
      end else begin
         if (w_pop)
            r_rptr <= r_rptr + PTR_ONE;
         if (w_push)
            r_wptr <= r_wptr + PTR_ONE;
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   // queue storage; contents are masked by the valid count so no reset is needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wptr]    <= r_out_addr;
         r_q_instr[r_wptr] <= imem_rdata;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] r_redirect_count;
   logic [31:0] r_bubble_count;

   // saturating redirect and bubble counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirect_count <= '0;
         r_bubble_count   <= '0;
      end else begin
         if (w_redir && (r_redirect_count != 32'hFFFF_FFFF))
            r_redirect_count <= r_redirect_count + 32'd1;
         if (!w_valid && (r_bubble_count != 32'hFFFF_FFFF))
            r_bubble_count <= r_bubble_count + 32'd1;
      end
   end

   assign redirect_count = r_redirect_count;
   assign bubble_count   = r_bubble_count;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue with RESET_PC=0x3000.
// A behavioural memory answers one cycle after each grant; expected decode PCs
// are queued per phase and checked as decode consumes them.
`timescale 1ns/1ps
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        jump_branch;
   logic        jump_target;
   logic        jump_reg;
   logic [31:0] jr_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        instr_valid_id;
   logic [31:0] pc_id;
   logic [31:0] instr_id;

   ifetch_queue #(
      .RESET_PC (32'h0000_3000),
      .QDEPTH   (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .jump_branch    (jump_branch),
      .jump_target    (jump_target),
      .jump_reg       (jump_reg),
      .jr_pc          (jr_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .instr_valid_id (instr_valid_id),
      .pc_id          (pc_id),
      .instr_id       (instr_id)
   );

   always #5 clk = ~clk;

   // kind: bit2 jump_reg, bit1 jump_target, bit0 jump_branch
   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  kind;
      logic [31:0] jr;
      logic        gnt0;
   } trig_t;

   trig_t       trig_q[$];
   logic [31:0] sb_q[$];
   logic [31:0] grant_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          gnt_mode = 0;
   int          cyc = 0;

   function automatic logic [31:0] imem_f(input logic [31:0] a);
      case (a)
         32'h0000_3000: imem_f = 32'h1000_0004;   // beq $0,$0,+4
         32'h0000_3FFC: imem_f = 32'h0800_0800;   // j 0x800
         default:       imem_f = {a[15:0] ^ 16'h5A5A, a[15:0]};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++)
         sb_q.push_back(start + 32'(4 * i));
   endtask

   // one clock cycle: decode decision, scoreboard check, memory response
   task automatic tick();
      logic        granted;
      logic [31:0] gaddr;
      logic [31:0] e;
      jump_branch = 1'b0;
      jump_target = 1'b0;
      jump_reg    = 1'b0;
      imem_gnt    = (gnt_mode == 0) ? 1'b1 : cyc[0];
      if (instr_valid_id && !stall && trig_q.size() > 0 && pc_id == trig_q[0].pc) begin
         jump_reg    = trig_q[0].kind[2];
         jump_target = trig_q[0].kind[1];
         jump_branch = trig_q[0].kind[0];
         jr_pc       = trig_q[0].jr;
         if (trig_q[0].gnt0)
            imem_gnt = 1'b0;
         void'(trig_q.pop_front());
      end
      #1;
      if (instr_valid_id && !stall && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         $display("consume pc=%h instr=%h (expect pc=%h)", pc_id, instr_id, e);
         check("pc_id", pc_id, e);
         check("instr_id", instr_id, imem_f(e));
      end
      granted = imem_req & imem_gnt;
      gaddr   = imem_addr;
      if (granted)
         grant_log.push_back(gaddr);
      @(posedge clk);
      #1;
      cyc++;
      imem_rvalid = granted;
      imem_rdata  = granted ? imem_f(gaddr) : 32'hDEAD_BEEF;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (sb_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'd0, imem_req},       32'd0);
      check({tag, "_addr"},  imem_addr,               32'h0000_3000);
      check({tag, "_valid"}, {31'd0, instr_valid_id}, 32'd0);
      check({tag, "_pc"},    pc_id,                   32'd0);
      check({tag, "_instr"}, instr_id,                32'd0);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      stall       = 1'b0;
      jump_branch = 1'b0;
      jump_target = 1'b0;
      jump_reg    = 1'b0;
      jr_pc       = 32'd0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      imem_gnt    = 1'b0;
      sb_q.delete();
      trig_q.delete();
      grant_log.delete();
      cyc = 0;
      #1;
      check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0000_3000);
   endtask

   // the grant following the first grant of address a must be for address b
   task automatic check_next_grant(input string tag, input logic [31:0] a, input logic [31:0] b);
      int k = -1;
      for (int i = 0; i < grant_log.size(); i++)
         if (k < 0 && grant_log[i] == a)
            k = i;
      check(tag, (k >= 0 && k + 1 < grant_log.size()) ? grant_log[k+1] : 32'hFFFF_FFFF, b);
   endtask

   initial begin
      // sequential fetch with gnt always high
      gnt_mode = 0;
      do_reset();
      push_seq(32'h3000, 6);
      run(80);
      check("grant0", grant_log[0], 32'h3000);
      check("grant1", grant_log[1], 32'h3004);
      check("grant2", grant_log[2], 32'h3008);

      // stall with full queue
      do_reset();
      push_seq(32'h3000, 2);
      run(40);
      stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i >= 3) begin
            check("stall_req",   {31'd0, imem_req},       32'd0);
            check("stall_valid", {31'd0, instr_valid_id}, 32'd1);
            check("stall_pc",    pc_id,                   32'h3008);
            check("stall_instr", instr_id,                imem_f(32'h3008));
         end
         tick();
      end
      stall = 1'b0;
      push_seq(32'h3008, 4);
      run(60);

      // taken BEQ at 0x3000, offset 4 words
      do_reset();
      trig_q.push_back('{pc: 32'h3000, kind: 3'b001, jr: 32'd0, gnt0: 1'b0});
      sb_q.push_back(32'h3000);
      sb_q.push_back(32'h3004);
      push_seq(32'h3014, 3);
      run(80);

      // JR at 0x3010 to 0x4000, no grant in the redirect cycle
      do_reset();
      trig_q.push_back('{pc: 32'h3010, kind: 3'b100, jr: 32'h4000, gnt0: 1'b1});
      push_seq(32'h3000, 6);
      push_seq(32'h4000, 2);
      run(80);
      check_next_grant("jr3010_grant", 32'h3014, 32'h4000);

      // JR at 0x300C: delay slot request is withheld in the redirect cycle
      do_reset();
      trig_q.push_back('{pc: 32'h300C, kind: 3'b100, jr: 32'h4000, gnt0: 1'b1});
      push_seq(32'h3000, 5);
      push_seq(32'h4000, 2);
      run(80);
      check_next_grant("jr300c_grant", 32'h3010, 32'h4000);

      // JR beats BEQ at 0x3000, then J beats BEQ at 0x3FFC
      do_reset();
      trig_q.push_back('{pc: 32'h3000, kind: 3'b101, jr: 32'h3FF4, gnt0: 1'b0});
      trig_q.push_back('{pc: 32'h3FFC, kind: 3'b011, jr: 32'd0,    gnt0: 1'b0});
      push_seq(32'h3000, 2);
      push_seq(32'h3FF4, 4);
      push_seq(32'h2000, 2);
      run(120);

      // toggling grant, then reset in the middle of a transfer
      gnt_mode = 1;
      do_reset();
      push_seq(32'h3000, 5);
      run(120);
      for (int i = 0; i < 20 && imem_rvalid !== 1'b1; i++)
         tick();
      check("inflight_before_rst", {31'd0, imem_rvalid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      do_reset();
      // stale response presented right after reset must be ignored
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      push_seq(32'h3000, 6);
      run(120);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage placed directly upstream of decode. It generates the fetch PC and issues requests to instruction memory. It buffers returned instructions in a small queue and presents one {pc, instr} pair per cycle to decode. It applies decode's stall and redirect outputs (branch, jump, jump-register) with MIPS single-delay-slot semantics.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
stall  input  1  decode hold; head entry not consumed this cycle
jump_branch  input  1  taken conditional branch for the instruction in ID
jump_target  input  1  J/JAL for the instruction in ID
jump_reg  input  1  JR/JALR for the instruction in ID
jr_pc  input  32  register target (forwarded rs) for jump_reg
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address (bits[1:0]=0)
imem_gnt  input  1  request accepted this cycle
imem_rdata  input  32  returned instruction
imem_rvalid  input  1  data valid, exactly 1 cycle after req&gnt
instr_valid_id  output  1  head entry valid
pc_id  output  32  PC of head entry
instr_id  output  32  instruction of head entry

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, queue empty, outstanding=0, no pending redirect. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid_id=0, pc_id=0, instr_id=0. First request is issued in the first cycle after rst deasserts.
- Issue: imem_req=1 when count+outstanding<QDEPTH. On req&gnt: outstanding=1, fetch_pc+=4. The request is held stable until gnt. At most 1 outstanding request.
- Response: on imem_rvalid, enqueue {addr,rdata} if addr==expected_pc, otherwise drop. A simultaneous dequeue frees the slot in the same cycle.
- Consume: when instr_valid_id & ~stall, pop the head, and expected_pc advances to the next sequential or redirected PC. While stall=1, outputs stay stable.
- Redirect: a redirect is any of jump_branch/jump_target/jump_reg qualified by instr_valid_id & ~stall.
  - jump_branch: target = pc_id+4+{sext(instr_id[15:0]),2'b00}.
  - jump_target: target = {pc_id_plus4[31:28], instr_id[25:0], 2'b00}.
  - jump_reg: target = jr_pc.
  - If more than one flag is asserted, priority is jump_reg > jump_target > jump_branch.
- Delay slot: the instruction at pc_id+4 is always delivered next. After it, the target is delivered.
  - Queue entries beyond the delay slot are flushed in the redirect cycle.
  - If pc_id+4 was already requested, fetch_pc<=target.
  - Otherwise the target is stored in pending_tgt. fetch_pc continues to pc_id+4, then loads pending_tgt when that request is granted.
  - A response in flight that is neither the delay slot nor the target is dropped via the expected_pc filter.
- A redirect whose delay slot is itself a branch is not architecturally defined. The block still follows the same rules with no lockup.
- Wrap-around: PC arithmetic is modulo 2^32. Queue pointers wrap modulo QDEPTH.
- Full queue: no request is issued, and imem_req=0.
- Empty queue: instr_valid_id=0. Decode inputs are ignored.

Optional Feature:
IFETCH_PERF_CNT_EN
- When defined, two extra outputs are added:
  - redirect_count (32): counts redirects.
  - bubble_count (32): counts cycles with instr_valid_id=0 and rst=0.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h0000_3000, imem_gnt=1 always → after rst falls: imem_addr 3000, 3004, 3008…; pc_id sequence 3000, 3004 with no gaps.
- Hold stall=1 for 5 cycles with queue full → imem_req=0, pc_id/instr_id unchanged; after release, consumption resumes with no instruction lost or duplicated.
- BEQ at 3000 with imm=16'h0004, jump_branch=1 → decode sees 3000, 3004 (delay slot), 3014; fetched 3008 is dropped.
- JR at 3010 with jr_pc=32'h0000_4000, delay slot not yet requested (imem_gnt=0 that cycle) → imem_addr 3014, then 4000; pc_id 3010, 3014, 4000.
- J at 3FFC with instr_id[25:0]=26'h0000800 → pc_id 3FFC, 4000, then 2000.
- imem_gnt toggling 1/0 each cycle, plus rst asserted mid-transfer → no duplicate PCs; on rst all outputs return to reset values immediately and refetch restarts at RESET_PC.
